// File: rtl/lc3b_mem_responder_if.sv
// Request/response bus between an LC-3b memory initiator and the memory responder.
// The initiator holds mem_read/mem_write and its operands steady until it sees the one-cycle mem_resp pulse.
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata,
        output mem_err
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency LC-3b word memory responder with byte-lane writes.
// Optional protocol checker enabled by defining MEM_PROTOCOL_CHECK_EN.
module lc3b_mem_responder #(
    parameter int unsigned DELAY     = 2,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    lc3b_mem_responder_if.slave    bus,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);
    localparam int unsigned WORDS   = 2 ** ADDR_BITS;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [1:0]     be_q, be_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    rdata_q;
    logic           accept;
    logic           enter_resp;
    logic [ADDR_BITS-1:0] idx_d;

    logic [15:0]    mem_q [WORDS];

    // State register and captured transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; the counter reaching zero in BUSY is seen as cnt_q==1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    accept  = 1'b1;
                    rd_d    = bus.mem_read;
                    wr_d    = bus.mem_write;
                    be_d    = bus.mem_byte_enable;
                    addr_d  = bus.mem_address;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (DELAY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Commit and read happen on the edge that enters RESP, using next-state
    // operands so DELAY=1 (IDLE->RESP directly) sees the freshly captured values.
    assign enter_resp = !rst && (state_d == RESP) && (state_q != RESP);
    assign idx_d      = addr_d[ADDR_BITS:1];

    always_ff @(posedge clk) begin
        if (enter_resp && wr_d) begin
            if (be_d[0]) mem_q[idx_d][7:0]  <= wdata_d[7:0];
            if (be_d[1]) mem_q[idx_d][15:8] <= wdata_d[15:8];
        end
    end

    // Nonblocking read of the array returns the pre-write word on read+write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (enter_resp && rd_d) begin
            rdata_q <= mem_q[idx_d];
        end
    end

`ifdef MEM_PROTOCOL_CHECK_EN
    logic err_q, err_d;
    logic busy_changed;

    assign busy_changed = (state_q == BUSY) &&
        ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata, bus.mem_byte_enable} !=
         {rd_q, wr_q, addr_q, wdata_q, be_q});

    always_comb begin
        err_d = err_q | (accept && bus.mem_read && bus.mem_write) | busy_changed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Address bit 0 and bits above ADDR_BITS are ignored by the array index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q, accept};

    // Output logic.
    always_comb begin
        bus.mem_resp  = (state_q == RESP);
        bus.mem_rdata = rdata_q;
        dbg_state_o   = state_q;
`ifdef MEM_PROTOCOL_CHECK_EN
        bus.mem_err   = err_q;
`else
        bus.mem_err   = 1'b0;
`endif
    end

endmodule

// File: doc/lc3b_mem_responder.md
LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

Interface
REQ-001 SHALL have parameter DELAY, default 2: cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 8: the word array holds 2^ADDR_BITS 16-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_read  input  1  read request, held by the initiator until mem_resp.
REQ-006 SHALL have port mem_write  input  1  write request, held by the initiator until mem_resp.
REQ-007 SHALL have port mem_byte_enable  input  2  write byte lanes; bit0 = low byte [7:0], bit1 = high byte [15:8].
REQ-008 SHALL have port mem_address  input  16  byte address; bit 0 ignored; bits [ADDR_BITS:1] index the array; higher bits ignored (aliasing).
REQ-009 SHALL have port mem_wdata  input  16  write data (lc3b_word).
REQ-010 SHALL have port mem_resp  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_rdata  output  16  read data (lc3b_word), valid while mem_resp=1.
REQ-012 SHALL have port mem_err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: when mem_read|mem_write=1, SHALL capture address, wdata, byte_enable and op, load the counter with DELAY-1, and go to BUSY (DELAY>1) or RESP (DELAY=1).
REQ-015 BUSY: SHALL decrement the counter each cycle and go to RESP when the counter reaches 0.
REQ-016 A request sampled in IDLE at edge T SHALL produce mem_resp=1 in exactly the cycle following edge T+DELAY-1 (DELAY=1: the cycle after acceptance).
REQ-017 RESP: mem_resp=1 for exactly one cycle, then IDLE; a request present in the first IDLE cycle SHALL be accepted as a new transaction.
REQ-018 Reads SHALL drive mem_rdata with the captured-address word during RESP; mem_rdata SHALL hold its last value otherwise.
REQ-019 Writes SHALL update only the enabled byte lanes, committing at the edge that enters RESP; byte_enable=00 SHALL complete with mem_resp and leave memory unchanged.
REQ-020 With mem_read and mem_write both 1, SHALL perform the write and return the pre-write word on mem_rdata.
REQ-021 SHALL complete a transaction using the captured values even if the inputs change or drop during BUSY.
REQ-022 Back-to-back accesses to one address SHALL observe all earlier committed writes.
REQ-023 Array contents SHALL be unaffected by rst; reads of never-written words are undefined and SHALL NOT be checked.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter=0, mem_resp=0, mem_rdata=16'h0000, mem_err=0.
REQ-025 rst during BUSY SHALL discard the pending transaction; a pending write SHALL NOT commit, and no mem_resp SHALL follow.
REQ-026 rst has priority over every other event in the same cycle.

Configuration
REQ-027 Macro MEM_PROTOCOL_CHECK_EN defined: mem_err SHALL set and stay set until rst when (a) mem_read and mem_write are both 1 at acceptance, or (b) during BUSY, mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable differ from the captured values.
REQ-028 Macro MEM_PROTOCOL_CHECK_EN undefined: mem_err SHALL be constant 0 and no checker logic SHALL be synthesized; function is otherwise identical.

Verification
REQ-029 Reset: DELAY=2; assert rst 2 cycles -> mem_resp=0, mem_rdata=16'h0000, mem_err=0.
REQ-030 Write/read: write 16'hBEEF to 16'h0010 with be=11, then read 16'h0010 -> mem_resp exactly 2 cycles after each acceptance; read returns 16'hBEEF.
REQ-031 Byte lanes: over 16'hBEEF at 16'h0010, write 16'h1234 with be=01, then 16'h5600 with be=10 -> read returns 16'h5634.
REQ-032 Alias/odd address: ADDR_BITS=8; write 16'hA5A5 to 16'h0021 -> read at 16'h0220 returns 16'hA5A5.
REQ-033 Reset mid-op: write 16'h0000 to 16'h0010 holding 16'h5634; assert rst in BUSY -> no mem_resp; subsequent read returns 16'h5634.
REQ-034 Checker (MEM_PROTOCOL_CHECK_EN defined): change mem_address during BUSY -> mem_err=1, still 1 after resp, cleared only by rst; macro undefined -> mem_err stays 0.
